// File: rtl/sram_write_scheduler.sv
// Two-client round-robin write scheduler feeding the SRAM controller's renderer slot.
// Accepted writes queue in a small FIFO; the head is presented until the slot-done pulse retires it.
module sram_write_scheduler #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aValid,
  output logic                     aReady,
  input  logic [ADDR_W-1:0]        aAddress,
  input  logic [DATA_W-1:0]        aData,
  input  logic                     bValid,
  output logic                     bReady,
  input  logic [ADDR_W-1:0]        bAddress,
  input  logic [DATA_W-1:0]        bData,
  input  logic                     slotDone,
  output logic [ADDR_W-1:0]        reqAddress,
  output logic [DATA_W-1:0]        reqDout,
  output logic                     reqWeN,
  output logic                     reqOeN,
  output logic                     reqDen,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RR_A, RR_B} rr_t;

  rr_t               rr_q, rr_d;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic full, empty, push_a, push_b, push, pop;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= RR_A;
    else      rr_q <= rr_d;
  end

  // With no requester, ready advertises the favoured client so a lone arrival is taken at once.
  always_comb begin
    aReady = 1'b0;
    bReady = 1'b0;
    if (!full) begin
      if (aValid && bValid) begin
        aReady = (rr_q == RR_A);
        bReady = (rr_q == RR_B);
      end else if (aValid) begin
        aReady = 1'b1;
      end else if (bValid) begin
        bReady = 1'b1;
      end else begin
        aReady = (rr_q == RR_A);
        bReady = (rr_q == RR_B);
      end
    end
    push_a = aValid && aReady;
    push_b = bValid && bReady;
    rr_d   = rr_q;
    if (push_a)      rr_d = RR_B;
    else if (push_b) rr_d = RR_A;
  end

  assign push      = push_a || push_b;
  assign pop       = slotDone && !empty;
  assign push_addr = push_a ? aAddress : bAddress;
  assign push_data = push_a ? aData : bData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // Driven from registered state only, so an asynchronous reset drops the request immediately.
  always_comb begin
    reqAddress = '0;
    reqDout    = '0;
    reqWeN     = 1'b1;
    reqOeN     = 1'b1;
    reqDen     = 1'b0;
    if (!empty) begin
      reqAddress = addr_mem[rd_ptr];
      reqDout    = data_mem[rd_ptr];
      reqWeN     = 1'b0;
      reqDen     = 1'b1;
    end
  end

  assign busy  = !empty;
  assign level = count;

  a_no_overflow:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: tb/tb_sram_write_scheduler.sv
// Directed self-checking bench for sram_write_scheduler: reset, single write, round-robin,
// full FIFO back-pressure, simultaneous push/pop and asynchronous reset mid-operation.
module tb_sram_write_scheduler;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              aValid = 1'b0, bValid = 1'b0, slotDone = 1'b0;
  logic              aReady, bReady;
  logic [ADDR_W-1:0] aAddress = '0, bAddress = '0;
  logic [DATA_W-1:0] aData = '0, bData = '0;
  logic [ADDR_W-1:0] reqAddress;
  logic [DATA_W-1:0] reqDout;
  logic              reqWeN, reqOeN, reqDen, busy;
  logic [$clog2(DEPTH):0] level;

  int pass_cnt = 0;
  int total_cnt = 0;

  sram_write_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aReady(aReady), .aAddress(aAddress), .aData(aData),
    .bValid(bValid), .bReady(bReady), .bAddress(bAddress), .bData(bData),
    .slotDone(slotDone),
    .reqAddress(reqAddress), .reqDout(reqDout),
    .reqWeN(reqWeN), .reqOeN(reqOeN), .reqDen(reqDen),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    step();
    rst = 1'b0; aValid = 1'b0; bValid = 1'b0; slotDone = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; aValid = 1'b1; aAddress = 20'h00010; aData = 32'h1111_2222;
    for (int i = 0; i < 3; i++) begin
      slotDone = i[0];
      step();
      total_cnt++; if (reqWeN !== 1'b1) $display("FAIL reset_wen got=%b exp=1", reqWeN); else pass_cnt++;
      total_cnt++; if (reqDen !== 1'b0) $display("FAIL reset_den got=%b exp=0", reqDen); else pass_cnt++;
      total_cnt++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else pass_cnt++;
      total_cnt++; if (reqAddress !== 20'h0) $display("FAIL reset_addr got=%h exp=0", reqAddress); else pass_cnt++;
    end
    total_cnt++; if (reqOeN !== 1'b1 || busy !== 1'b0) $display("FAIL reset_oe_busy got=%b%b exp=10", reqOeN, busy); else pass_cnt++;
    rst = 1'b1; slotDone = 1'b0;
    #1;
    total_cnt++; if (aReady !== 1'b1) $display("FAIL reset_first_ready got=%b exp=1", aReady); else pass_cnt++;
    step();
    aValid = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd1) $display("FAIL reset_first_accept got=%0d exp=1", level); else pass_cnt++;
    total_cnt++; if (reqAddress !== 20'h00010) $display("FAIL reset_first_addr got=%h exp=00010", reqAddress); else pass_cnt++;
    slotDone = 1'b1;
    step();
    slotDone = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd0) $display("FAIL reset_drain got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_rr_idle();
    // rr now favours B after the A push above
    aValid = 1'b0; bValid = 1'b0;
    #1;
    total_cnt++; if ({aReady, bReady} !== 2'b01) $display("FAIL rr_idle_b got=%b exp=01", {aReady, bReady}); else pass_cnt++;
    step();
    total_cnt++; if ({aReady, bReady} !== 2'b01) $display("FAIL rr_idle_hold got=%b exp=01", {aReady, bReady}); else pass_cnt++;
    bValid = 1'b1; bAddress = 20'h00020; bData = 32'h0000_0020;
    #1;
    total_cnt++; if (bReady !== 1'b1) $display("FAIL rr_b_ready got=%b exp=1", bReady); else pass_cnt++;
    step();
    bValid = 1'b0;
    #1;
    total_cnt++; if ({aReady, bReady} !== 2'b10) $display("FAIL rr_idle_a got=%b exp=10", {aReady, bReady}); else pass_cnt++;
    slotDone = 1'b1;
    step();
    slotDone = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd0) $display("FAIL rr_drain got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_single_write();
    aValid = 1'b1; aAddress = 20'h00010; aData = 32'hDEADBEEF; slotDone = 1'b1;
    #1;
    total_cnt++; if (aReady !== 1'b1) $display("FAIL single_ready got=%b exp=1", aReady); else pass_cnt++;
    step();
    aValid = 1'b0; slotDone = 1'b0;
    #1;
    total_cnt++; if (reqWeN !== 1'b0 || reqDen !== 1'b1 || reqOeN !== 1'b1)
      $display("FAIL single_ctrl got=%b%b%b exp=011", reqWeN, reqDen, reqOeN); else pass_cnt++;
    total_cnt++; if (reqAddress !== 20'h00010) $display("FAIL single_addr got=%h exp=00010", reqAddress); else pass_cnt++;
    total_cnt++; if (reqDout !== 32'hDEADBEEF) $display("FAIL single_data got=%h exp=deadbeef", reqDout); else pass_cnt++;
    total_cnt++; if (level !== 3'd1 || busy !== 1'b1) $display("FAIL single_level got=%0d/%b exp=1/1", level, busy); else pass_cnt++;
    step();
    slotDone = 1'b1;
    #1;
    total_cnt++; if (reqWeN !== 1'b0 || reqAddress !== 20'h00010) $display("FAIL single_hold got=%b/%h exp=0/00010", reqWeN, reqAddress); else pass_cnt++;
    step();
    slotDone = 1'b0;
    #1;
    total_cnt++; if (reqWeN !== 1'b1 || reqAddress !== 20'h0 || reqDout !== 32'h0 || level !== 3'd0)
      $display("FAIL single_idle got=%b/%h/%h/%0d exp=1/0/0/0", reqWeN, reqAddress, reqDout, level); else pass_cnt++;
  endtask

  task automatic test_contention();
    int wi;
    logic [ADDR_W-1:0] exp_a;
    reset_dut();
    wi = 0;
    slotDone = 1'b1;
    for (int c = 0; c < 11; c++) begin
      aValid = (c < 8); bValid = (c < 8);
      aAddress = ADDR_W'(32'h100 + (c + 1) / 2); aData = {12'h0, aAddress};
      bAddress = ADDR_W'(32'h200 + c / 2);       bData = {12'h0, bAddress};
      #1;
      if (c < 8) begin
        total_cnt++; if ({aReady, bReady} !== ((c % 2 == 0) ? 2'b10 : 2'b01))
          $display("FAIL contention_ready c=%0d got=%b", c, {aReady, bReady}); else pass_cnt++;
      end
      if (reqWeN == 1'b0) begin
        exp_a = (wi % 2 == 0) ? ADDR_W'(32'h100 + wi / 2) : ADDR_W'(32'h200 + wi / 2);
        total_cnt++; if (reqAddress !== exp_a || reqDout !== {12'h0, exp_a})
          $display("FAIL contention_order idx=%0d got=%h/%h exp=%h", wi, reqAddress, reqDout, exp_a); else pass_cnt++;
        wi++;
      end
      step();
    end
    slotDone = 1'b0;
    total_cnt++; if (wi !== 8) $display("FAIL contention_count got=%0d exp=8", wi); else pass_cnt++;
    total_cnt++; if (level !== 3'd0) $display("FAIL contention_level got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_full();
    reset_dut();
    slotDone = 1'b0; bValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      aValid = 1'b1; aAddress = ADDR_W'(32'h300 + i); aData = {12'h0, aAddress};
      #1;
      total_cnt++; if (aReady !== (i < 4)) $display("FAIL full_ready i=%0d got=%b exp=%b", i, aReady, (i < 4)); else pass_cnt++;
      total_cnt++; if (level !== 3'(i)) $display("FAIL full_level i=%0d got=%0d exp=%0d", i, level, i); else pass_cnt++;
      if (i < 4) step();
    end
    for (int j = 0; j < 6; j++) begin
      aValid = (j < 2); slotDone = 1'b1;
      #1;
      if (j == 0) begin
        total_cnt++; if (aReady !== 1'b0 || level !== 3'd4) $display("FAIL full_pop_cycle got=%b/%0d exp=0/4", aReady, level); else pass_cnt++;
      end
      if (j == 1) begin
        total_cnt++; if (aReady !== 1'b1 || level !== 3'd3) $display("FAIL full_reaccept got=%b/%0d exp=1/3", aReady, level); else pass_cnt++;
      end
      if (j < 5) begin
        total_cnt++; if (reqWeN !== 1'b0 || reqAddress !== ADDR_W'(32'h300 + j))
          $display("FAIL full_order j=%0d got=%b/%h exp=0/%h", j, reqWeN, reqAddress, ADDR_W'(32'h300 + j)); else pass_cnt++;
      end
      step();
    end
    slotDone = 1'b0;
    total_cnt++; if (level !== 3'd0 || reqWeN !== 1'b1) $display("FAIL full_drain got=%0d/%b exp=0/1", level, reqWeN); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    reset_dut();
    slotDone = 1'b0; aValid = 1'b1;
    aAddress = 20'h00400; aData = 32'h0000_0400;
    step();
    aAddress = 20'h00401; aData = 32'h0000_0401;
    step();
    aAddress = 20'h00402; aData = 32'h0000_0402; slotDone = 1'b1;
    #1;
    total_cnt++; if (level !== 3'd2 || aReady !== 1'b1) $display("FAIL b2b_pre got=%0d/%b exp=2/1", level, aReady); else pass_cnt++;
    total_cnt++; if (reqAddress !== 20'h00400) $display("FAIL b2b_head0 got=%h exp=00400", reqAddress); else pass_cnt++;
    step();
    aValid = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd2) $display("FAIL b2b_level got=%0d exp=2", level); else pass_cnt++;
    total_cnt++; if (reqAddress !== 20'h00401) $display("FAIL b2b_head1 got=%h exp=00401", reqAddress); else pass_cnt++;
    step();
    total_cnt++; if (reqAddress !== 20'h00402 || reqDout !== 32'h0000_0402 || level !== 3'd1)
      $display("FAIL b2b_tail got=%h/%h/%0d exp=00402/00000402/1", reqAddress, reqDout, level); else pass_cnt++;
    step();
    slotDone = 1'b0;
    total_cnt++; if (level !== 3'd0) $display("FAIL b2b_drain got=%0d exp=0", level); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    slotDone = 1'b0; aValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aAddress = ADDR_W'(32'h500 + i); aData = {12'h0, aAddress};
      step();
    end
    aValid = 1'b0;
    #1;
    total_cnt++; if (level !== 3'd3 || reqWeN !== 1'b0) $display("FAIL mid_pre got=%0d/%b exp=3/0", level, reqWeN); else pass_cnt++;
    #1;
    rst = 1'b0;
    #1;
    total_cnt++; if (reqWeN !== 1'b1 || reqDen !== 1'b0) $display("FAIL mid_async got=%b/%b exp=1/0", reqWeN, reqDen); else pass_cnt++;
    total_cnt++; if (level !== 3'd0 || busy !== 1'b0) $display("FAIL mid_level got=%0d/%b exp=0/0", level, busy); else pass_cnt++;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slotDone = i[0];
      step();
      total_cnt++; if (reqWeN !== 1'b1 || level !== 3'd0) $display("FAIL mid_stale i=%0d got=%b/%0d exp=1/0", i, reqWeN, level); else pass_cnt++;
    end
    slotDone = 1'b0; aValid = 1'b1; aAddress = 20'h00555; aData = 32'h0000_0555;
    step();
    aValid = 1'b0;
    #1;
    total_cnt++; if (reqAddress !== 20'h00555 || level !== 3'd1) $display("FAIL mid_fresh got=%h/%0d exp=00555/1", reqAddress, level); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_rr_idle();
    test_single_write();
    test_contention();
    test_full();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sram_write_scheduler.md
Name: sram_write_scheduler

Overview:
- Shares the SRAM controller's renderer time slot between two write clients: the text renderer (client A) and the fill/scroll engine (client B).
- Arbitrates the two clients round-robin and queues accepted writes in a small FIFO.
- Drives the head entry onto the renderer request lines and retires it on the controller's per-slot done pulse.
- Sits between the renderer/scroll logic and the SRAM controller; runs on the same 25 MHz clock.

Parameters:
ADDR_W, 20, SRAM word address width
DATA_W, 32, SRAM data width
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  25 MHz system clock
rst  input  1  asynchronous reset, active-low
aValid  input  1  client A write request
aReady  output  1  client A accepted this cycle when aValid&aReady
aAddress  input  ADDR_W  client A word address
aData  input  DATA_W  client A write data
bValid  input  1  client B write request
bReady  output  1  client B accepted this cycle when bValid&bReady
bAddress  input  ADDR_W  client B word address
bData  input  DATA_W  client B write data
slotDone  input  1  controller renderer-slot done pulse (high every other cycle)
reqAddress  output  ADDR_W  to controller renderer request address
reqDout  output  DATA_W  to controller renderer request write data
reqWeN  output  1  write enable, active-low
reqOeN  output  1  output enable, active-low
reqDen  output  1  data bus drive enable
busy  output  1  FIFO non-empty
level  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst low, asynchronous): FIFO empty, read/write pointers 0, level=0, round-robin pointer = A. Outputs: reqWeN=1, reqOeN=1, reqDen=0, reqAddress=0, reqDout=0, busy=0.
- Arbitration (combinational), at most one push per cycle:
  - full: aReady=bReady=0.
  - Only one client valid: that client gets ready=1.
  - Both valid: the client named by the RR pointer wins; the loser's ready=0.
  - Neither valid: both readies follow the RR pointer (ready only for the favoured client). Ready never depends on slotDone.
- RR pointer update: after any accepted push it points to the other client. It is unchanged on idle cycles.
- Push: the accepted client's address/data is written at the write pointer on the clock edge; the write pointer wraps modulo DEPTH.
- Presentation:
  - FIFO non-empty: reqAddress/reqDout = head entry, reqWeN=0, reqOeN=1, reqDen=1, all held stable for the whole cycle.
  - FIFO empty: idle values as in reset, with reqAddress/reqDout = 0.
- Pop: on a clock edge where slotDone=1 and the FIFO is non-empty, the head is retired and the read pointer wraps modulo DEPTH. slotDone while empty is ignored.
- Simultaneous push and pop: both take effect and level is unchanged.
  - Full with pop in the same cycle: no push that cycle, because ready is computed from the registered full flag and there is no bypass.
  - Empty with push in the same cycle: no pop, because presentation reflects only registered contents; the earliest write to SRAM is the cycle after acceptance.
- Latency: acceptance to earliest retire is 1 cycle (push at edge N; head valid in cycle N+1; retires at edge N+1 if slotDone=1 then). Worst case behind k entries is 2k+2 cycles.
- Ordering: the SRAM write order equals the acceptance order. Per-client order is always preserved.
- level = entries in FIFO, range 0..DEPTH. busy = (level != 0).
- Reset mid-operation discards all queued entries, and any in-flight presentation drops to idle immediately (asynchronously).
- No overflow or underflow is possible by construction. Assertion: a push never occurs while full, and a pop never occurs while empty.

Test Plan:
- Reset: hold rst=0 with aValid=1 -> aReady=0 is not required, but reqWeN=1, reqDen=0, level=0 throughout. After release, the first edge with aValid=1 accepts.
- Single write: aValid pulse with aAddress=0x00010 and aData=0xDEADBEEF; slotDone toggles 0,1,… -> next cycle reqWeN=0 with reqAddress=0x00010 and reqDout=0xDEADBEEF, held until the first slotDone=1 cycle; then idle with level=0.
- Contention: aValid=bValid=1 continuously, A addresses 0x100+i, B addresses 0x200+i -> acceptance and SRAM write order 0x100,0x200,0x101,0x201,…
- Full: slotDone held 0, A pushes 5 times -> 4 accepted, level=4, aReady=0 on the 5th. Enable slotDone -> entries retire in order, and the 5th is accepted on the first cycle after level drops to 3.
- Simultaneous push/pop: level=2 with slotDone=1 and aValid=1 in the same cycle -> level stays 2, the head retires, and the new entry lands at the tail.
- Reset mid-operation: level=3, rst pulled low asynchronously mid-cycle -> reqWeN=1 and reqDen=0 within the same cycle. After release level=0, and no stale entry is ever presented.
